// File: rtl/core_sequencer_if.sv
// Control/status bundle between the stage sequencer (master) and the core datapath (slave).
interface core_sequencer_if #(
    parameter int RETIRE_W = 32
);
    logic                START;
    logic                HALT_REQ;
    logic                INSTR_READY;
    logic                MEM_ACCESS;
    logic                MEM_READY;
    logic                FETCH_ENABLED;
    logic                DECODER_ENABLED;
    logic                EXEC_ENABLED;
    logic                MEMORY_ENABLED;
    logic                WRITER_ENABLED;
    logic                PC_UPDATE;
    logic [2:0]          STAGE;
    logic                BUSY;
    logic                ERROR;
    logic [RETIRE_W-1:0] RETIRED;

    modport master (
        input  START, HALT_REQ, INSTR_READY, MEM_ACCESS, MEM_READY,
        output FETCH_ENABLED, DECODER_ENABLED, EXEC_ENABLED, MEMORY_ENABLED,
               WRITER_ENABLED, PC_UPDATE, STAGE, BUSY, ERROR, RETIRED
    );

    modport slave (
        output START, HALT_REQ, INSTR_READY, MEM_ACCESS, MEM_READY,
        input  FETCH_ENABLED, DECODER_ENABLED, EXEC_ENABLED, MEMORY_ENABLED,
               WRITER_ENABLED, PC_UPDATE, STAGE, BUSY, ERROR, RETIRED
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I stage sequencer: one-hot stage enables, memory wait timeout,
// halt at instruction boundary, saturating retired-instruction counter.
module core_sequencer #(
    parameter int MAX_WAIT = 16,
    parameter int RETIRE_W = 32
) (
    input  logic              CLK,
    input  logic              RSTN,
    core_sequencer_if.master  bus
);
    localparam int WCNT_W = $clog2(MAX_WAIT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMORY = 3'd4,
        S_WRITE  = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_halt_pend;
    logic                r_error;
    logic [RETIRE_W-1:0] r_retired;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_busy;

    assign w_busy = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC) ||
                    (r_state == S_MEMORY) || (r_state == S_WRITE);

    always_comb begin
        w_next    = r_state;
        w_waiting = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.HALT_REQ)   w_next = S_HALTED;
                else if (bus.START) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.INSTR_READY) begin
                    w_next = S_DECODE;
                end else begin
                    w_waiting = 1'b1;
                    if (r_wcnt == WAIT_LAST) begin
                        w_timeout = 1'b1;
                        w_next    = S_HALTED;
                    end
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = bus.MEM_ACCESS ? S_MEMORY : S_WRITE;
            S_MEMORY: begin
                if (bus.MEM_READY) begin
                    w_next = S_WRITE;
                end else begin
                    w_waiting = 1'b1;
                    if (r_wcnt == WAIT_LAST) begin
                        w_timeout = 1'b1;
                        w_next    = S_HALTED;
                    end
                end
            end
            // START is deliberately not re-checked between instructions
            S_WRITE:  w_next = (r_halt_pend || bus.HALT_REQ) ? S_HALTED : S_FETCH;
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_halt_pend <= 1'b0;
            r_error     <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_state <= w_next;
            // Any cycle that is not a ready-low stall restarts the count, so entry is always from 0
            r_wcnt  <= w_waiting ? r_wcnt + 1'b1 : '0;
            if (w_busy && bus.HALT_REQ) r_halt_pend <= 1'b1;
            if (w_timeout)              r_error     <= 1'b1;
            if ((r_state == S_WRITE) && !(&r_retired)) r_retired <= r_retired + 1'b1;
        end
    end

    assign bus.FETCH_ENABLED   = (r_state == S_FETCH);
    assign bus.DECODER_ENABLED = (r_state == S_DECODE);
    assign bus.EXEC_ENABLED    = (r_state == S_EXEC);
    assign bus.MEMORY_ENABLED  = (r_state == S_MEMORY);
    assign bus.WRITER_ENABLED  = (r_state == S_WRITE);
    assign bus.PC_UPDATE       = (r_state == S_WRITE);
    assign bus.STAGE           = r_state;
    assign bus.BUSY            = w_busy;
    assign bus.ERROR           = r_error;
    assign bus.RETIRED         = r_retired;
endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle stage controller for the RV32I core. Steps one instruction at a time through fetch, decode, execute, memory and write-back by raising exactly one stage-enable per cycle; WRITER_ENABLED is the qualifier the write-back stage uses to commit into the register file. It waits on instruction/data memory handshakes, aborts on a memory timeout, honours a halt request at an instruction boundary, and counts retired instructions.

## Interface
- MAX_WAIT, 16: cycles a wait state may spend with its ready low before timeout (≥2).
- RETIRE_W, 32: width of retired-instruction counter.
- CLK  input  1  clock; all state changes on posedge.
- RSTN  input  1  reset; synchronous and active-low.
- START  input  1  level; leave IDLE and begin fetching.
- HALT_REQ  input  1  request stop at next instruction boundary.
- INSTR_READY  input  1  instruction memory returned the fetched word.
- MEM_ACCESS  input  1  decoded instruction is a load/store; sampled in EXEC.
- MEM_READY  input  1  data memory completed the access.
- FETCH_ENABLED, DECODER_ENABLED, EXEC_ENABLED, MEMORY_ENABLED, WRITER_ENABLED  output  1 each  stage enables, one-hot or all zero.
- PC_UPDATE  output  1  advance PC; high exactly in WRITE.
- STAGE  output  3  current state code.
- BUSY  output  1  state is FETCH..WRITE.
- ERROR  output  1  sticky memory-timeout flag.
- RETIRED  output  RETIRE_W  instructions completed.

## Operation
- States/STAGE codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEMORY=4, WRITE=5, HALTED=6; code 7 unused, treated as IDLE next cycle.
- Moore outputs decoded from the state register: FETCH_ENABLED=(FETCH), DECODER_ENABLED=(DECODE), EXEC_ENABLED=(EXEC), MEMORY_ENABLED=(MEMORY), WRITER_ENABLED=PC_UPDATE=(WRITE).
- IDLE: HALT_REQ → HALTED (priority over START); else START → FETCH; else stay.
- FETCH: INSTR_READY → DECODE; else stay, wait counter counts.
- DECODE: unconditional → EXEC.
- EXEC: MEM_ACCESS=1 → MEMORY, else → WRITE.
- MEMORY: MEM_READY → WRITE; else stay, wait counter counts.
- WRITE: RETIRED += 1, saturating at all-ones; → HALTED if halt pending or HALT_REQ high this cycle, else → FETCH (START not re-checked).
- HALTED: stays until RSTN low.
- Halt pending: set by HALT_REQ in any BUSY state, cleared by reset; never aborts an instruction mid-flight.
- Wait counter: cleared on every entry to FETCH or MEMORY; increments each cycle in that state with its ready low. Ready low on the cycle the count equals MAX_WAIT-1 → ERROR set, → HALTED; no WRITE, RETIRED unchanged. Ready high on that same cycle wins (normal transition, no error).

## Timing
- Reset (RSTN low at posedge): state IDLE, all enables 0, PC_UPDATE 0, STAGE 0, BUSY 0, ERROR 0, RETIRED 0, halt pending 0, wait counter 0. Reset mid-instruction abandons it; no WRITE pulse.
- START high at posedge in IDLE → FETCH_ENABLED high the following cycle.
- Zero-wait ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WRITE); zero-wait load/store: 5 cycles. Each ready-low cycle adds one.
- Back-to-back: WRITE followed directly by FETCH, no bubble.
- RETIRED visible incremented the cycle after WRITE.
- Timeout: ready low for MAX_WAIT consecutive cycles in a wait state → HALTED with ERROR=1 on the next cycle.

## Test plan
- Reset then START=1, INSTR_READY=1, MEM_ACCESS=0: STAGE 1,2,3,5,1…; WRITER_ENABLED one cycle in every 4; RETIRED=3 after three WRITEs.
- MEM_ACCESS=1, MEM_READY low 3 cycles then high: MEMORY_ENABLED 4 cycles, then single WRITE pulse, total 8 cycles per instruction.
- HALT_REQ pulsed in DECODE: instruction completes (WRITE seen, RETIRED+1), then STAGE=6, BUSY=0, no further FETCH despite START=1.
- MAX_WAIT=16, INSTR_READY held low: after 16 FETCH cycles STAGE=6, ERROR=1, RETIRED unchanged; INSTR_READY high on 16th cycle instead → DECODE, ERROR=0.
- RSTN low during MEMORY: next cycle STAGE=0, all outputs 0, RETIRED=0; IDLE with START=1 and HALT_REQ=1 → HALTED directly.
- RETIRE_W=3: 9 instructions → RETIRED saturates at 7.
